// File: rtl/axis_spi_master.sv
// AXI-Stream to SPI master: one 32-bit input word becomes one SPI transfer whose
// received bits are returned on the output stream along with the chip-select index.
module axis_spi_master #(
  parameter int unsigned SPI_DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned CS_WIDTH       = 1,
  parameter bit          CPOL           = 1'b0,
  parameter bit          CPHA           = 1'b0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [31:0]         s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [CS_WIDTH-1:0] spi_cs_n,
  output logic                busy
);

  localparam int unsigned W     = SPI_DATA_WIDTH;
  localparam int unsigned EDGES = 2 * W;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t        state, next_state;
  logic [9:0]    cnt;
  logic [5:0]    edge_cnt;
  logic [W-2:0]  tx_sr;
  logic [W-1:0]  rx_sr;
  logic [3:0]    cs_idx;
  logic [31:0]   result;
  logic [CS_WIDTH-1:0] cs_sel;
  logic accept, cnt_last, edge_last, leading, sample_now, update_now, m_next_valid;

  generate
    if (W < 28) begin : g_unused
      logic unused_tdata;
      assign unused_tdata = ^s_axis_tdata[27:W];
    end
  endgenerate

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign cnt_last  = (cnt == 10'(CLK_DIV - 1));
  assign edge_last = (edge_cnt == 6'(EDGES - 1));
  // edge_cnt holds edges already emitted, so the upcoming edge is leading when it is even
  assign leading   = ~edge_cnt[0];
  assign m_next_valid = (m_axis_tvalid & ~m_axis_tready) | ((state == GAP) & cnt_last);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LEAD;
      LEAD:    if (cnt_last) next_state = SHIFT;
      SHIFT:   if (cnt_last && edge_last) next_state = TRAIL;
      TRAIL:   if (cnt_last) next_state = GAP;
      GAP:     if (cnt_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sample_now = 1'b0;
    update_now = 1'b0;
    if (state == SHIFT && cnt_last) begin
      if (CPHA) begin
        sample_now = ~leading;
        update_now = leading & (edge_cnt != '0);
      end else begin
        sample_now = leading;
        update_now = ~leading & ~edge_last;
      end
    end
  end

  always_comb begin
    cs_sel = '1;
    for (int unsigned i = 0; i < CS_WIDTH; i++) begin
      cs_sel[i] = (s_axis_tdata[31:28] != 4'(i));
    end
  end

  always_comb begin
    result         = '0;
    result[31:28]  = cs_idx;
    result[W-1:0]  = rx_sr;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt           <= '0;
      edge_cnt      <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      cs_idx        <= '0;
      spi_sclk      <= CPOL;
      spi_mosi      <= 1'b0;
      spi_cs_n      <= '1;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      busy          <= 1'b0;
    end else begin
      // ready is precomputed from the next-cycle state so the port stays a flop
      s_axis_tready <= (next_state == IDLE) & ~m_next_valid;
      busy          <= (next_state != IDLE);
      m_axis_tvalid <= m_next_valid;

      if (state == IDLE || cnt_last) cnt <= '0;
      else                           cnt <= cnt + 10'd1;

      if (accept) begin
        tx_sr    <= s_axis_tdata[W-2:0];
        rx_sr    <= '0;
        cs_idx   <= s_axis_tdata[31:28];
        spi_mosi <= s_axis_tdata[W-1];
        spi_cs_n <= cs_sel;
        edge_cnt <= '0;
      end

      if (state == SHIFT && cnt_last) begin
        spi_sclk <= ~spi_sclk;
        edge_cnt <= edge_cnt + 6'd1;
      end
      if (sample_now) rx_sr <= {rx_sr[W-2:0], spi_miso};
      if (update_now) begin
        spi_mosi <= tx_sr[W-2];
        tx_sr    <= {tx_sr[W-3:0], 1'b0};
      end

      if (state == TRAIL && cnt_last) spi_cs_n <= '1;
      if (state == GAP && cnt_last) begin
        spi_mosi     <= 1'b0;
        m_axis_tdata <= result;
      end
    end
  end

endmodule

// File: tb/tb_axis_spi_master.sv
// Directed bench for axis_spi_master: default mode-0 loopback instance plus an
// 8-bit mode-3 instance with two chip selects talking to a small slave model.
module tb_axis_spi_master;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s0_tdata, m0_tdata;
  logic s0_tvalid, s0_tready, m0_tvalid, m0_tready, sclk0, mosi0, miso0, busy0;
  logic [0:0] cs0;
  assign miso0 = mosi0;

  logic [31:0] s1_tdata, m1_tdata;
  logic s1_tvalid, s1_tready, m1_tvalid, m1_tready, sclk1, mosi1, miso1, busy1;
  logic [1:0] cs1;
  logic [7:0] slv_word = 8'h3C;

  axis_spi_master dut0 (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
    .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
    .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs_n(cs0), .busy(busy0)
  );

  axis_spi_master #(
    .SPI_DATA_WIDTH(8), .CLK_DIV(2), .CS_WIDTH(2), .CPOL(1'b1), .CPHA(1'b1)
  ) dut1 (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
    .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(cs1), .busy(busy1)
  );

  // Mode-3 slave on cs1[1]: presents the next bit on each falling (leading) SCLK edge
  initial begin
    miso1 = 1'b0;
    forever begin
      @(negedge cs1[1]);
      for (int k = 7; k >= 0; k--) begin
        @(negedge sclk1);
        miso1 = slv_word[k];
      end
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [31:0] d);
    int n = 0;
    while (!s0_tready && n < 500) begin
      step();
      n++;
    end
    chk("send0_ready", 32'(s0_tready), 32'd1);
    s0_tdata  = d;
    s0_tvalid = 1'b1;
    step();
    s0_tvalid = 1'b0;
  endtask

  // Called in cycle T+1; stops in the first cycle m0_tvalid is seen (n = offset from T)
  task automatic mon0(output int lo, output int first_lo, output int edges,
                      output int tv_at, output int rdy_hi, output logic [31:0] rd);
    logic prev;
    lo = 0; first_lo = 0; edges = 0; tv_at = 0; rdy_hi = 0; rd = '0; prev = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (!cs0[0]) begin
        lo++;
        if (first_lo == 0) first_lo = n;
      end
      if (sclk0 != prev) edges++;
      prev = sclk0;
      if (s0_tready) rdy_hi++;
      if (m0_tvalid) begin
        tv_at = n;
        rd    = m0_tdata;
        break;
      end
      step();
    end
  endtask

  task automatic ack0();
    m0_tready = 1'b1;
    step();
    m0_tready = 1'b0;
    chk("ack_tvalid_low", 32'(m0_tvalid), 32'd0);
    chk("ack_tready_up", 32'(s0_tready), 32'd1);
  endtask

  int lo, first_lo, edges, tv_at, rdy_hi, viol, lo_other, got, wi, hi_run, min_gap, low_starts;
  logic [31:0] rd, held;
  logic [7:0] mbits;
  logic prev1, acc, in_low;
  logic [31:0] words [4];
  logic [31:0] res [4];

  initial begin
    s0_tdata = '0; s0_tvalid = 1'b0; m0_tready = 1'b0;
    s1_tdata = '0; s1_tvalid = 1'b0; m1_tready = 1'b0;

    // asynchronous reset, observed before any clock edge
    #1 aresetn = 1'b0;
    #1;
    chk("rst_s_tready", 32'(s0_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m0_tvalid), 32'd0);
    chk("rst_m_tdata", m0_tdata, 32'd0);
    chk("rst_cs_n", 32'(cs0), 32'd1);
    chk("rst_sclk", 32'(sclk0), 32'd0);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_sclk_cpol1", 32'(sclk1), 32'd1);
    chk("rst_cs_n_w2", 32'(cs1), 32'd3);
    @(posedge clk);
    #1 aresetn = 1'b1;
    step();
    chk("rel_tready0", 32'(s0_tready), 32'd1);
    chk("rel_tready1", 32'(s1_tready), 32'd1);

    // default loopback transfer
    send0(32'h0000A5C3);
    chk("t1_busy", 32'(busy0), 32'd1);
    chk("t1_mosi_msb", 32'(mosi0), 32'd1);
    mon0(lo, first_lo, edges, tv_at, rdy_hi, rd);
    chk("t1_cs_low", 32'(lo), 32'd136);
    chk("t1_cs_first", 32'(first_lo), 32'd1);
    chk("t1_edges", 32'(edges), 32'd32);
    chk("t1_tvalid_at", 32'(tv_at), 32'd141);
    chk("t1_rdy_hi", 32'(rdy_hi), 32'd0);
    chk("t1_rdata", rd, 32'h0000A5C3);
    chk("t1_idle_mosi", 32'(mosi0), 32'd0);
    ack0();

    // bits [27:W] ignored
    send0(32'h0ABC5A3C);
    mon0(lo, first_lo, edges, tv_at, rdy_hi, rd);
    chk("t2_rdata", rd, 32'h00005A3C);
    ack0();

    // mode 3, W=8, two chip selects, slave returns 0x3C
    chk("t3_ready", 32'(s1_tready), 32'd1);
    s1_tdata = 32'h100000F0; s1_tvalid = 1'b1;
    step();
    s1_tvalid = 1'b0;
    lo = 0; lo_other = 0; edges = 0; mbits = '0; tv_at = 0; rd = '0; prev1 = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      if (!cs1[1]) lo++;
      if (!cs1[0]) lo_other++;
      if (sclk1 != prev1) begin
        edges++;
        if (sclk1) mbits = {mbits[6:0], mosi1};
      end
      prev1 = sclk1;
      if (m1_tvalid) begin
        tv_at = n;
        rd    = m1_tdata;
        break;
      end
      step();
    end
    chk("t3_cs1_low", 32'(lo), 32'd36);
    chk("t3_cs0_low", 32'(lo_other), 32'd0);
    chk("t3_edges", 32'(edges), 32'd16);
    chk("t3_mosi_bits", 32'(mbits), 32'h000000F0);
    chk("t3_tvalid_at", 32'(tv_at), 32'd39);
    chk("t3_rdata", rd, 32'h1000003C);
    m1_tready = 1'b1;
    step();
    m1_tready = 1'b0;
    chk("t3_ack_ready", 32'(s1_tready), 32'd1);

    // backpressure on the result while a second word is offered
    send0(32'h00001234);
    mon0(lo, first_lo, edges, tv_at, rdy_hi, rd);
    chk("t4_rdata", rd, 32'h00001234);
    held = m0_tdata;
    s0_tdata = 32'h00004321; s0_tvalid = 1'b1;
    viol = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (!m0_tvalid || m0_tdata !== held || s0_tready || !cs0[0]) viol++;
    end
    chk("t4_hold_viol", 32'(viol), 32'd0);
    m0_tready = 1'b1;
    step();
    m0_tready = 1'b0;
    chk("t4_u1_tvalid", 32'(m0_tvalid), 32'd0);
    chk("t4_u1_tready", 32'(s0_tready), 32'd1);
    chk("t4_u1_cs_high", 32'(cs0), 32'd1);
    step();
    s0_tvalid = 1'b0;
    chk("t4_u2_cs_low", 32'(cs0), 32'd0);
    mon0(lo, first_lo, edges, tv_at, rdy_hi, rd);
    chk("t4_second_at", 32'(tv_at), 32'd141);
    chk("t4_second_rdata", rd, 32'h00004321);
    ack0();

    // out-of-range chip select
    send0(32'h50009C0F);
    mon0(lo, first_lo, edges, tv_at, rdy_hi, rd);
    chk("t5_cs_low", 32'(lo), 32'd0);
    chk("t5_edges", 32'(edges), 32'd32);
    chk("t5_tvalid_at", 32'(tv_at), 32'd141);
    chk("t5_rdata", rd, 32'h50009C0F);
    ack0();

    // reset in the middle of SHIFT
    send0(32'h0000FFFF);
    repeat (9) step();
    chk("t6_pre_sclk", 32'(sclk0), 32'd1);
    chk("t6_pre_mosi", 32'(mosi0), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("t6_sclk", 32'(sclk0), 32'd0);
    chk("t6_mosi", 32'(mosi0), 32'd0);
    chk("t6_cs_n", 32'(cs0), 32'd1);
    chk("t6_busy", 32'(busy0), 32'd0);
    chk("t6_m_tdata", m0_tdata, 32'd0);
    chk("t6_s_tready", 32'(s0_tready), 32'd0);
    repeat (3) step();
    aresetn = 1'b1;
    step();
    chk("t6_rel_tready", 32'(s0_tready), 32'd1);
    viol = 0;
    for (int n = 0; n < 150; n++) begin
      step();
      if (m0_tvalid || !cs0[0]) viol++;
    end
    chk("t6_no_result", 32'(viol), 32'd0);
    send0(32'h0000C3A5);
    mon0(lo, first_lo, edges, tv_at, rdy_hi, rd);
    chk("t6_next_low", 32'(lo), 32'd136);
    chk("t6_next_at", 32'(tv_at), 32'd141);
    chk("t6_next_rdata", rd, 32'h0000C3A5);
    ack0();

    // back-to-back stream with the output always ready
    words[0] = 32'h00000001; words[1] = 32'h00008000;
    words[2] = 32'h0000FFFF; words[3] = 32'h00007E81;
    m0_tready = 1'b1; wi = 0; got = 0; hi_run = 0; min_gap = 1000; low_starts = 0; in_low = 1'b0;
    s0_tdata = words[0]; s0_tvalid = 1'b1;
    for (int n = 0; n < 2000 && got < 4; n++) begin
      acc = s0_tvalid & s0_tready;
      if (m0_tvalid) begin
        res[got[1:0]] = m0_tdata;
        got++;
      end
      if (cs0[0]) begin
        hi_run++;
        in_low = 1'b0;
      end else begin
        if (!in_low) begin
          if (low_starts > 0 && hi_run < min_gap) min_gap = hi_run;
          low_starts++;
        end
        hi_run = 0;
        in_low = 1'b1;
      end
      step();
      if (acc) begin
        wi++;
        if (wi < 4) s0_tdata = words[wi[1:0]];
        else s0_tvalid = 1'b0;
      end
    end
    m0_tready = 1'b0;
    chk("t7_count", 32'(got), 32'd4);
    chk("t7_low_starts", 32'(low_starts), 32'd4);
    chk("t7_gap_ok", 32'(min_gap >= 5 && min_gap < 1000), 32'd1);
    chk("t7_res0", res[0], 32'h00000001);
    chk("t7_res1", res[1], 32'h00008000);
    chk("t7_res2", res[2], 32'h0000FFFF);
    chk("t7_res3", res[3], 32'h00007E81);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
